// File: rtl/alu32_seq_unit.sv
// Request/response 32-bit ALU with an iterative shift-add multiplier.
// One op in flight; result and flags held until the response handshake.
module alu32_seq_unit #(
    parameter int MUL_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [3:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_c,
    output logic        rsp_zero,
    output logic        rsp_cout,
    output logic        busy
);
    localparam int N  = 32 / MUL_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t        state;
    logic [31:0]   mcand;
    logic [31:0]   mplier;
    logic [31:0]   acc;
    logic [CW-1:0] cnt;

    logic [31:0] alu_c;
    logic        alu_cout;
    logic [32:0] sum;
    logic [32:0] diff;
    logic [31:0] part;
    logic [31:0] acc_nxt;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign sum  = {1'b0, req_a} + {1'b0, req_b};
    assign diff = {1'b0, req_a} - {1'b0, req_b};

    always_comb begin
        alu_c    = '0;
        alu_cout = 1'b0;
        unique case (req_op)
            4'b0000: alu_c = ~req_a;
            4'b0001: {alu_cout, alu_c} = sum;
            4'b0010: {alu_cout, alu_c} = diff;
            4'b0100: alu_c = req_a & req_b;
            4'b0101: alu_c = req_a | req_b;
            4'b0110: alu_c = req_a ^ req_b;
            4'b0111: alu_c = req_a >> 1;
            4'b1000: alu_c = req_a << 1;
            default: alu_c = '0;
        endcase
    end

    // Partial products for the MUL_BITS low multiplier bits of this step
    always_comb begin
        part = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier[i]) part = part + (mcand << i);
        end
    end

    assign acc_nxt = acc + part;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            rsp_c    <= '0;
            rsp_zero <= 1'b0;
            rsp_cout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_op == 4'b0011) begin
                            mcand  <= req_a;
                            mplier <= req_b;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= MUL;
                        end else begin
                            rsp_c    <= alu_c;
                            rsp_zero <= (alu_c == '0);
                            rsp_cout <= alu_cout;
                            state    <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << MUL_BITS;
                    mplier <= mplier >> MUL_BITS;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        rsp_c    <= acc_nxt;
                        rsp_zero <= (acc_nxt == '0);
                        rsp_cout <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu32_seq_unit.sv
// Randomized bench for alu32_seq_unit against an arithmetic reference.
// A second instance exercises the 4-bit-per-cycle multiplier.
module tb_alu32_seq_unit;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_c;
    logic        rsp_zero;
    logic        rsp_cout;
    logic        busy;

    logic        q_valid;
    logic        q_ready;
    logic [31:0] q_a;
    logic [31:0] q_b;
    logic [3:0]  q_op;
    logic        q_rvalid;
    logic [31:0] q_c;
    logic        q_zero;
    logic        q_cout;
    logic        q_busy;

    int n_vec;
    int n_err;

    alu32_seq_unit #(.MUL_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_zero(rsp_zero),
        .rsp_cout(rsp_cout), .busy(busy)
    );

    alu32_seq_unit #(.MUL_BITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(q_valid), .req_ready(q_ready),
        .req_a(q_a), .req_b(q_b), .req_op(q_op),
        .rsp_valid(q_rvalid), .rsp_ready(1'b1),
        .rsp_c(q_c), .rsp_zero(q_zero),
        .rsp_cout(q_cout), .busy(q_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, obs, exp);
        end
    endtask

    // Returns {zero, cout, c} from the op definitions
    function automatic logic [33:0] ref_op(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [3:0]  op);
        logic [31:0] c;
        logic        co;
        logic [63:0] w;
        c  = 32'd0;
        co = 1'b0;
        w  = 64'd0;
        case (op)
            4'd0: c = ~a;
            4'd1: begin
                w  = 64'(a) + 64'(b);
                c  = w[31:0];
                co = w[32];
            end
            4'd2: begin
                c  = a - b;
                co = (a < b);
            end
            4'd3: begin
                w = 64'(a) * 64'(b);
                c = w[31:0];
            end
            4'd4: c = a & b;
            4'd5: c = a | b;
            4'd6: c = a ^ b;
            4'd7: c = a / 2;
            4'd8: c = a * 2;
            default: c = 32'd0;
        endcase
        return {(c == 32'd0), co, c};
    endfunction

    task automatic do_op(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [3:0]  op,
                         input int          stall,
                         output logic [31:0] c_obs);
        logic [33:0] e;
        int w;
        int lat;
        int exp_lat;
        e = ref_op(a, b, op);
        exp_lat = (op == 4'd3) ? 33 : 1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!req_ready && w < 100);
        chk("idle_wait", 32'(req_ready), 32'd1);
        rsp_ready = (stall == 0);
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_op = op;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            req_valid = 1'b1;
            req_a = $urandom;
            req_b = $urandom;
            req_op = 4'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        req_valid = 1'b0;
        c_obs = rsp_c;
        chk($sformatf("lat op%0d", op), lat, exp_lat);
        chk($sformatf("c op%0d", op), rsp_c, e[31:0]);
        chk($sformatf("cout op%0d", op), 32'(rsp_cout), 32'(e[32]));
        chk($sformatf("zero op%0d", op), 32'(rsp_zero), 32'(e[33]));
        if (stall > 0) begin
            for (int k = 0; k < stall; k++) begin
                req_valid = 1'b1;
                req_a = $urandom;
                req_op = 4'd1;
                @(posedge clk);
                #1;
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_c", rsp_c, e[31:0]);
                chk("hold_rdy", 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("rel_busy", 32'(busy), 32'd0);
            chk("rel_rdy", 32'(req_ready), 32'd1);
            chk("rel_valid", 32'(rsp_valid), 32'd0);
        end
    endtask

    logic [31:0] exp_t [9];
    logic [31:0] c_obs;
    int lat;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b1;
        q_valid = 1'b0;
        q_a = '0;
        q_b = '0;
        q_op = '0;
        exp_t = '{32'hFFFF_FFF0, 28, 2, 195, 13, 15, 2, 7, 30};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_c", rsp_c, 32'd0);
        chk("rst_zero", 32'(rsp_zero), 32'd0);
        chk("rst_cout", 32'(rsp_cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(32'd15, 32'd13, 4'(i), 0, c_obs);
            chk($sformatf("dir op%0d", i), c_obs, exp_t[i]);
        end
        do_op(32'd13, 32'd15, 4'd2, 0, c_obs);
        do_op(32'hFFFF_FFFF, 32'd1, 4'd1, 0, c_obs);
        do_op(32'd15, 32'd13, 4'd9, 0, c_obs);
        do_op(32'd15, 32'd13, 4'd15, 0, c_obs);
        do_op(32'd15, 32'd13, 4'd1, 5, c_obs);
        do_op(32'h1_0000, 32'h1_0000, 4'd3, 0, c_obs);

        @(negedge clk);
        q_valid = 1'b1;
        q_a = 32'd15;
        q_b = 32'd13;
        q_op = 4'd3;
        @(posedge clk);
        #1;
        q_valid = 1'b0;
        lat = 1;
        while (!q_rvalid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("m4_lat", lat, 32'd9);
        chk("m4_c", q_c, 32'd195);
        chk("m4_cout", 32'(q_cout), 32'd0);

        do_op(32'd15, 32'd13, 4'd1, 0, c_obs);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1;
        req_a = 32'd1234;
        req_b = 32'd5678;
        req_op = 4'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_c", rsp_c, 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd15, 32'd13, 4'd1, 0, c_obs);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [3:0]  op;
            int st;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            op = 4'($urandom_range(0, 15));
            if (op > 4'd8 && $urandom_range(0, 1) == 0)
                op = 4'($urandom_range(0, 8));
            st = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0;
            do_op(a, b, op, st, c_obs);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
